// File: rtl/circle_pkg.sv
// rtl/circle_pkg.sv - shared attribute type, widths and ring helper for the circle sprite renderer
package circle_pkg;
    localparam int LATENCY = 3;
    localparam int H_W     = 11;
    localparam int V_W     = 10;
    localparam int R_W     = 8;

    typedef struct packed {
        logic [H_W-1:0] x;
        logic [V_W-1:0] y;
        logic [R_W-1:0] r;
        logic [23:0]    color;
        logic           ring;
        logic           enable;
    } circle_attr_t;

    // Inner edge of a ring; collapses to 0 so thin circles render as filled discs.
    function automatic logic [R_W-1:0] inner_radius(input logic [R_W-1:0] r, input int thick);
        logic [R_W-1:0] w_t;
        w_t = R_W'(thick);
        inner_radius = (r <= w_t) ? '0 : r - w_t;
    endfunction
endpackage

// File: rtl/circle_hit_pipe.sv
// rtl/circle_hit_pipe.sv - one channel's distance/compare pipeline; hit is valid after two register stages
module circle_hit_pipe
    import circle_pkg::*;
#(
    parameter int RING_THICK = 4
) (
    input  logic           i_clk,
    input  logic           i_rstn,
    input  logic [H_W-1:0] i_hcount,
    input  logic [V_W-1:0] i_vcount,
    input  circle_attr_t   i_attr,
    output logic           o_hit,
    output logic [23:0]    o_color
);
    localparam int D_W   = ((H_W > V_W) ? H_W : V_W) + 1;
    localparam int D2_W  = 2 * D_W + 1;
    localparam int RR_W  = 2 * R_W;
    localparam int CMP_W = (D2_W > RR_W) ? D2_W : RR_W;

    logic signed [D_W-1:0]   w_dx;
    logic signed [D_W-1:0]   w_dy;
    logic [R_W-1:0]          w_inner;
    logic [RR_W-1:0]         w_r2;
    logic [RR_W-1:0]         w_inner2;
    logic signed [2*D_W-1:0] w_dx_ext;
    logic signed [2*D_W-1:0] w_dy_ext;
    logic signed [2*D_W-1:0] w_dx2;
    logic signed [2*D_W-1:0] w_dy2;
    logic [D2_W-1:0]         w_d2;

    logic signed [D_W-1:0] r_dx;
    logic signed [D_W-1:0] r_dy;
    logic [RR_W-1:0]       r_r2_s1;
    logic [RR_W-1:0]       r_in2_s1;
    logic                  r_ring_s1;
    logic                  r_en_s1;
    logic [23:0]           r_col_s1;

    logic [D2_W-1:0]       r_d2;
    logic [RR_W-1:0]       r_r2_s2;
    logic [RR_W-1:0]       r_in2_s2;
    logic                  r_ring_s2;
    logic                  r_en_s2;
    logic [23:0]           r_col_s2;

    // Zero-extend before subtracting so off-screen centres give true negative offsets.
    assign w_dx     = $signed(D_W'(i_hcount)) - $signed(D_W'(i_attr.x));
    assign w_dy     = $signed(D_W'(i_vcount)) - $signed(D_W'(i_attr.y));
    assign w_inner  = inner_radius(i_attr.r, RING_THICK);
    assign w_r2     = RR_W'(i_attr.r) * RR_W'(i_attr.r);
    assign w_inner2 = RR_W'(w_inner) * RR_W'(w_inner);

    assign w_dx_ext = (2*D_W)'(r_dx);
    assign w_dy_ext = (2*D_W)'(r_dy);
    assign w_dx2    = w_dx_ext * w_dx_ext;
    assign w_dy2    = w_dy_ext * w_dy_ext;
    assign w_d2     = D2_W'($unsigned(w_dx2)) + D2_W'($unsigned(w_dy2));

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_dx      <= '0;
            r_dy      <= '0;
            r_r2_s1   <= '0;
            r_in2_s1  <= '0;
            r_ring_s1 <= 1'b0;
            r_en_s1   <= 1'b0;
            r_col_s1  <= '0;
            r_d2      <= '0;
            r_r2_s2   <= '0;
            r_in2_s2  <= '0;
            r_ring_s2 <= 1'b0;
            r_en_s2   <= 1'b0;
            r_col_s2  <= '0;
        end else begin
            r_dx      <= w_dx;
            r_dy      <= w_dy;
            r_r2_s1   <= w_r2;
            r_in2_s1  <= w_inner2;
            r_ring_s1 <= i_attr.ring;
            r_en_s1   <= i_attr.enable;
            r_col_s1  <= i_attr.color;
            r_d2      <= w_d2;
            r_r2_s2   <= r_r2_s1;
            r_in2_s2  <= r_in2_s1;
            r_ring_s2 <= r_ring_s1;
            r_en_s2   <= r_en_s1;
            r_col_s2  <= r_col_s1;
        end
    end

    // Boundary (d2 == r^2) is outside; ring inner edge (d2 == inner^2) is inside.
    assign o_hit = r_en_s2 && (CMP_W'(r_d2) < CMP_W'(r_r2_s2))
                 && (!r_ring_s2 || (CMP_W'(r_d2) >= CMP_W'(r_in2_s2)));
    assign o_color = r_col_s2;
endmodule

// File: rtl/circle_sprite_array.sv
// rtl/circle_sprite_array.sv - tear-free multi-circle sprite overlay on a raster pixel stream
module circle_sprite_array
    import circle_pkg::*;
#(
    parameter int  N_CIRCLES  = 4,
    parameter int  H_WIDTH    = H_W,
    parameter int  V_WIDTH    = V_W,
    parameter int  R_WIDTH    = R_W,
    parameter int  RING_THICK = 4,
    localparam int IDX_W      = (N_CIRCLES > 1) ? $clog2(N_CIRCLES) : 1
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [H_WIDTH-1:0] hcount_in,
    input  logic [V_WIDTH-1:0] vcount_in,
    input  logic               frame_start_in,
    input  logic               wr_en_in,
    input  logic [IDX_W-1:0]   wr_idx_in,
    input  logic [H_WIDTH-1:0] wr_x_in,
    input  logic [V_WIDTH-1:0] wr_y_in,
    input  logic [R_WIDTH-1:0] wr_r_in,
    input  logic [23:0]        wr_color_in,
    input  logic               wr_ring_in,
    input  logic               wr_enable_in,
    output logic [H_WIDTH-1:0] hcount_out,
    output logic [V_WIDTH-1:0] vcount_out,
    output logic               hit_out,
    output logic [IDX_W-1:0]   hit_idx_out,
    output logic [7:0]         red_out,
    output logic [7:0]         green_out,
    output logic [7:0]         blue_out
);
    if (H_WIDTH != H_W || V_WIDTH != V_W || R_WIDTH != R_W) begin : g_width_check
        $error("circle_sprite_array: coordinate widths must match circle_pkg");
    end

    circle_attr_t         r_shadow     [N_CIRCLES];
    circle_attr_t         r_active     [N_CIRCLES];
    circle_attr_t         w_shadow_nxt [N_CIRCLES];
    circle_attr_t         w_view       [N_CIRCLES];
    circle_attr_t         w_wr_attr;
    logic [N_CIRCLES-1:0] w_hit;
    logic [23:0]          w_color      [N_CIRCLES];
    logic                 w_any;
    logic [IDX_W-1:0]     w_idx;
    logic [23:0]          w_win_color;
    logic [H_WIDTH-1:0]   r_hd         [LATENCY-1];
    logic [V_WIDTH-1:0]   r_vd         [LATENCY-1];

    assign w_wr_attr = '{x: wr_x_in, y: wr_y_in, r: wr_r_in, color: wr_color_in,
                         ring: wr_ring_in, enable: wr_enable_in};

    // The pixel presented with frame_start must already see the committed (and written-through) set.
    always_comb begin
        for (int i = 0; i < N_CIRCLES; i++) begin
            w_shadow_nxt[i] = r_shadow[i];
            if (wr_en_in && (32'(wr_idx_in) == i)) begin
                w_shadow_nxt[i] = w_wr_attr;
            end
            w_view[i] = frame_start_in ? w_shadow_nxt[i] : r_active[i];
        end
    end

    always_ff @(posedge clk_in) begin
        for (int i = 0; i < N_CIRCLES; i++) begin
            if (!rst_in) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end else begin
                r_shadow[i] <= w_shadow_nxt[i];
                r_active[i] <= w_view[i];
            end
        end
    end

    for (genvar g = 0; g < N_CIRCLES; g++) begin : g_ch
        circle_hit_pipe #(
            .RING_THICK (RING_THICK)
        ) u_pipe (
            .i_clk    (clk_in),
            .i_rstn   (rst_in),
            .i_hcount (hcount_in),
            .i_vcount (vcount_in),
            .i_attr   (w_view[g]),
            .o_hit    (w_hit[g]),
            .o_color  (w_color[g])
        );
    end

    // Scan from the top index down so the lowest hitting index wins.
    always_comb begin
        w_any       = 1'b0;
        w_idx       = '0;
        w_win_color = '0;
        for (int i = N_CIRCLES - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_any       = 1'b1;
                w_idx       = IDX_W'(i);
                w_win_color = w_color[i];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < LATENCY - 1; i++) begin
                r_hd[i] <= '0;
                r_vd[i] <= '0;
            end
            hcount_out  <= '0;
            vcount_out  <= '0;
            hit_out     <= 1'b0;
            hit_idx_out <= '0;
            red_out     <= '0;
            green_out   <= '0;
            blue_out    <= '0;
        end else begin
            r_hd[0] <= hcount_in;
            r_vd[0] <= vcount_in;
            for (int i = 1; i < LATENCY - 1; i++) begin
                r_hd[i] <= r_hd[i-1];
                r_vd[i] <= r_vd[i-1];
            end
            hcount_out  <= r_hd[LATENCY-2];
            vcount_out  <= r_vd[LATENCY-2];
            hit_out     <= w_any;
            hit_idx_out <= w_idx;
            red_out     <= w_win_color[23:16];
            green_out   <= w_win_color[15:8];
            blue_out    <= w_win_color[7:0];
        end
    end
endmodule

// File: tb/tb_circle_sprite_array.sv
// tb/tb_circle_sprite_array.sv - directed self-checking bench for circle_sprite_array
module tb_circle_sprite_array;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic [10:0] hcount_in = '0;
    logic [9:0]  vcount_in = '0;
    logic        frame_start_in = 1'b0;
    logic        wr_en_in = 1'b0;
    logic [1:0]  wr_idx_in = '0;
    logic [10:0] wr_x_in = '0;
    logic [9:0]  wr_y_in = '0;
    logic [7:0]  wr_r_in = '0;
    logic [23:0] wr_color_in = '0;
    logic        wr_ring_in = 1'b0;
    logic        wr_enable_in = 1'b0;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    logic        hit_out;
    logic [1:0]  hit_idx_out;
    logic [7:0]  red_out, green_out, blue_out;

    int errors = 0;
    int checks = 0;
    logic [26:0] obs;
    logic [26:0] exp_v;

    assign obs = {hit_out, hit_idx_out, red_out, green_out, blue_out};

    // Three channels, so wr_idx 3 is a genuinely out-of-range index.
    circle_sprite_array #(.N_CIRCLES(3)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .hcount_in(hcount_in), .vcount_in(vcount_in), .frame_start_in(frame_start_in),
        .wr_en_in(wr_en_in), .wr_idx_in(wr_idx_in), .wr_x_in(wr_x_in), .wr_y_in(wr_y_in),
        .wr_r_in(wr_r_in), .wr_color_in(wr_color_in), .wr_ring_in(wr_ring_in),
        .wr_enable_in(wr_enable_in),
        .hcount_out(hcount_out), .vcount_out(vcount_out), .hit_out(hit_out),
        .hit_idx_out(hit_idx_out), .red_out(red_out), .green_out(green_out), .blue_out(blue_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [26:0] px(input bit h, input int idx, input logic [23:0] c);
        return {h, 2'(idx), c};
    endfunction

    task automatic set_wr(input int idx, input int x, input int y, input int r,
                          input logic [23:0] col, input bit ring, input bit en);
        wr_idx_in = 2'(idx); wr_x_in = 11'(x); wr_y_in = 10'(y); wr_r_in = 8'(r);
        wr_color_in = col; wr_ring_in = ring; wr_enable_in = en;
    endtask

    task automatic write_ch(input int idx, input int x, input int y, input int r,
                            input logic [23:0] col, input bit ring, input bit en);
        @(negedge clk_in);
        set_wr(idx, x, y, r, col, ring, en);
        wr_en_in = 1'b1;
        @(negedge clk_in);
        wr_en_in = 1'b0;
    endtask

    task automatic commit();
        @(negedge clk_in);
        frame_start_in = 1'b1;
        @(negedge clk_in);
        frame_start_in = 1'b0;
    endtask

    // Present one pixel and wait until its result reaches the outputs.
    task automatic present(input int h, input int v, input bit fs, input bit wr);
        @(negedge clk_in);
        hcount_in = 11'(h); vcount_in = 10'(v); frame_start_in = fs; wr_en_in = wr;
        @(negedge clk_in);
        frame_start_in = 1'b0; wr_en_in = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_in);
            hcount_in = 11'($urandom); vcount_in = 10'($urandom);
            frame_start_in = 1'($urandom);
            set_wr(0, 640, 360, 255, 24'hFFFFFF, 1'b0, 1'b1);
            wr_en_in = 1'b1;
        end
        @(negedge clk_in);
        checks++;
        if ({obs, hcount_out, vcount_out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", {obs, hcount_out, vcount_out});
        end
        rst_in = 1'b1; wr_en_in = 1'b0; frame_start_in = 1'b0;
        present(640, 360, 1'b1, 1'b0);
        checks++;
        if (obs !== px(0, 0, 24'h0)) begin
            errors++; $display("FAIL reset_no_hit: got %h want %h", obs, px(0, 0, 24'h0));
        end
        checks++;
        if ({hcount_out, vcount_out} !== {11'd640, 10'd360}) begin
            errors++; $display("FAIL reset_align: got %0d,%0d want 640,360", hcount_out, vcount_out);
        end
    endtask

    task automatic test_fill();
        write_ch(0, 640, 360, 64, 24'hFF0000, 1'b0, 1'b1);
        commit();
        present(0, 0, 1'b0, 1'b0);
        @(negedge clk_in);
        hcount_in = 11'd640; vcount_in = 10'd360;
        @(negedge clk_in);
        @(negedge clk_in);
        checks++;
        if (hit_out !== 1'b0) begin
            errors++; $display("FAIL fill_latency_early: got %b want 0", hit_out);
        end
        @(negedge clk_in);
        exp_v = px(1, 0, 24'hFF0000);
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL fill_centre: got %h want %h", obs, exp_v);
        end
        checks++;
        if ({hcount_out, vcount_out} !== {11'd640, 10'd360}) begin
            errors++; $display("FAIL fill_align: got %0d,%0d want 640,360", hcount_out, vcount_out);
        end
        present(704, 360, 1'b0, 1'b0);
        checks++;
        if (obs !== px(0, 0, 24'h0)) begin
            errors++; $display("FAIL fill_boundary_x: got %h want %h", obs, px(0, 0, 24'h0));
        end
        present(703, 360, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL fill_inside_x: got %h want %h", obs, exp_v);
        end
        present(640, 296, 1'b0, 1'b0);
        checks++;
        if (obs !== px(0, 0, 24'h0)) begin
            errors++; $display("FAIL fill_boundary_negy: got %h want %h", obs, px(0, 0, 24'h0));
        end
        present(640, 297, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL fill_inside_negy: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_priority();
        write_ch(0, 100, 100, 20, 24'h00FF00, 1'b0, 1'b1);
        write_ch(2, 100, 100, 40, 24'h0000FF, 1'b0, 1'b1);
        commit();
        present(100, 100, 1'b0, 1'b0);
        checks++;
        if (obs !== px(1, 0, 24'h00FF00)) begin
            errors++; $display("FAIL prio_overlap: got %h want %h", obs, px(1, 0, 24'h00FF00));
        end
        present(130, 100, 1'b0, 1'b0);
        checks++;
        if (obs !== px(1, 2, 24'h0000FF)) begin
            errors++; $display("FAIL prio_outer: got %h want %h", obs, px(1, 2, 24'h0000FF));
        end
        present(150, 100, 1'b0, 1'b0);
        checks++;
        if (obs !== px(0, 0, 24'h0)) begin
            errors++; $display("FAIL prio_outside: got %h want %h", obs, px(0, 0, 24'h0));
        end
    endtask

    task automatic test_ring();
        write_ch(1, 200, 200, 30, 24'h123456, 1'b1, 1'b1);
        commit();
        present(200, 200, 1'b0, 1'b0);
        checks++;
        if (obs !== px(0, 0, 24'h0)) begin
            errors++; $display("FAIL ring_centre: got %h want %h", obs, px(0, 0, 24'h0));
        end
        present(228, 200, 1'b0, 1'b0);
        checks++;
        if (obs !== px(1, 1, 24'h123456)) begin
            errors++; $display("FAIL ring_band: got %h want %h", obs, px(1, 1, 24'h123456));
        end
        present(226, 200, 1'b0, 1'b0);
        checks++;
        if (obs !== px(1, 1, 24'h123456)) begin
            errors++; $display("FAIL ring_inner_edge: got %h want %h", obs, px(1, 1, 24'h123456));
        end
        present(225, 200, 1'b0, 1'b0);
        checks++;
        if (obs !== px(0, 0, 24'h0)) begin
            errors++; $display("FAIL ring_just_inside_hole: got %h want %h", obs, px(0, 0, 24'h0));
        end
        present(230, 200, 1'b0, 1'b0);
        checks++;
        if (obs !== px(0, 0, 24'h0)) begin
            errors++; $display("FAIL ring_outer_edge: got %h want %h", obs, px(0, 0, 24'h0));
        end
        present(200, 171, 1'b0, 1'b0);
        checks++;
        if (obs !== px(1, 1, 24'h123456)) begin
            errors++; $display("FAIL ring_negy: got %h want %h", obs, px(1, 1, 24'h123456));
        end
    endtask

    task automatic test_shadow();
        write_ch(0, 300, 100, 20, 24'h00FF00, 1'b0, 1'b1);
        present(100, 100, 1'b0, 1'b0);
        checks++;
        if (obs !== px(1, 0, 24'h00FF00)) begin
            errors++; $display("FAIL shadow_old_pos: got %h want %h", obs, px(1, 0, 24'h00FF00));
        end
        present(300, 100, 1'b0, 1'b0);
        checks++;
        if (obs !== px(0, 0, 24'h0)) begin
            errors++; $display("FAIL shadow_not_yet: got %h want %h", obs, px(0, 0, 24'h0));
        end
        present(300, 100, 1'b1, 1'b0);
        checks++;
        if (obs !== px(1, 0, 24'h00FF00)) begin
            errors++; $display("FAIL shadow_commit_pixel: got %h want %h", obs, px(1, 0, 24'h00FF00));
        end
        present(100, 100, 1'b0, 1'b0);
        checks++;
        if (obs !== px(1, 2, 24'h0000FF)) begin
            errors++; $display("FAIL shadow_moved_away: got %h want %h", obs, px(1, 2, 24'h0000FF));
        end
        set_wr(0, 500, 100, 20, 24'h00FF00, 1'b0, 1'b1);
        present(500, 100, 1'b1, 1'b1);
        checks++;
        if (obs !== px(1, 0, 24'h00FF00)) begin
            errors++; $display("FAIL shadow_write_through: got %h want %h", obs, px(1, 0, 24'h00FF00));
        end
        present(300, 100, 1'b0, 1'b0);
        checks++;
        if (obs !== px(0, 0, 24'h0)) begin
            errors++; $display("FAIL shadow_old_gone: got %h want %h", obs, px(0, 0, 24'h0));
        end
    endtask

    task automatic test_edges();
        write_ch(0, 0, 0, 10, 24'hABCDEF, 1'b0, 1'b1);
        write_ch(2, 150, 0, 20, 24'h00FF00, 1'b0, 1'b0);
        write_ch(3, 400, 0, 50, 24'hFFFFFF, 1'b0, 1'b1);
        commit();
        present(5, 5, 1'b0, 1'b0);
        checks++;
        if (obs !== px(1, 0, 24'hABCDEF)) begin
            errors++; $display("FAIL edge_origin_inside: got %h want %h", obs, px(1, 0, 24'hABCDEF));
        end
        present(9, 4, 1'b0, 1'b0);
        checks++;
        if (obs !== px(1, 0, 24'hABCDEF)) begin
            errors++; $display("FAIL edge_97: got %h want %h", obs, px(1, 0, 24'hABCDEF));
        end
        present(10, 0, 1'b0, 1'b0);
        checks++;
        if (obs !== px(0, 0, 24'h0)) begin
            errors++; $display("FAIL edge_boundary: got %h want %h", obs, px(0, 0, 24'h0));
        end
        present(2045, 5, 1'b0, 1'b0);
        checks++;
        if (obs !== px(0, 0, 24'h0)) begin
            errors++; $display("FAIL edge_hwrap: got %h want %h", obs, px(0, 0, 24'h0));
        end
        present(5, 1020, 1'b0, 1'b0);
        checks++;
        if (obs !== px(0, 0, 24'h0)) begin
            errors++; $display("FAIL edge_vwrap: got %h want %h", obs, px(0, 0, 24'h0));
        end
        present(150, 0, 1'b0, 1'b0);
        checks++;
        if (obs !== px(0, 0, 24'h0)) begin
            errors++; $display("FAIL edge_disabled: got %h want %h", obs, px(0, 0, 24'h0));
        end
        present(400, 0, 1'b0, 1'b0);
        checks++;
        if (obs !== px(0, 0, 24'h0)) begin
            errors++; $display("FAIL edge_bad_idx: got %h want %h", obs, px(0, 0, 24'h0));
        end
        write_ch(2, 400, 400, 0, 24'h00FF00, 1'b0, 1'b1);
        commit();
        present(400, 400, 1'b0, 1'b0);
        checks++;
        if (obs !== px(0, 0, 24'h0)) begin
            errors++; $display("FAIL edge_radius0: got %h want %h", obs, px(0, 0, 24'h0));
        end
        present(0, 0, 1'b0, 1'b0);
        @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        checks++;
        if ({obs, hcount_out, vcount_out} !== '0) begin
            errors++;
            $display("FAIL midframe_reset_outputs: got %h want 0", {obs, hcount_out, vcount_out});
        end
        @(negedge clk_in);
        rst_in = 1'b1;
        present(5, 5, 1'b1, 1'b0);
        checks++;
        if (obs !== px(0, 0, 24'h0)) begin
            errors++; $display("FAIL midframe_reset_attrs: got %h want %h", obs, px(0, 0, 24'h0));
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_priority();
        test_ring();
        test_shadow();
        test_edges();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
